// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: owns the PC, keeps at most one I-mem request in flight and buffers {pc, instr} for decode.
// Optional build macro FETCH_BYPASS_EN presents a response to decode in its arrival cycle when the queue is empty.
module fetch_prefetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_err,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [ADDR_W-1:0]  inst_pc_next,
  output logic               err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                outstanding_q, outstanding_d;
  logic                drop_q, drop_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0]  mem_data_q [DEPTH];
  logic [INSTR_W-1:0]  mem_data_d [DEPTH];
  logic [ADDR_W-1:0]   mem_pc_q   [DEPTH];
  logic [ADDR_W-1:0]   mem_pc_d   [DEPTH];

  logic q_empty_s, rsp_s, rsp_ok_s, rsp_bad_s, issue_s;
  logic bypass_s, head_valid_s, push_s, qpop_s;

  // Event decode: response qualification, issue permission, bypass, push/pop.
  always_comb begin
    q_empty_s = (count_q == CNT_W'(0));
    // A response only counts while a request is actually outstanding.
    rsp_s     = imem_rvalid & outstanding_q;
    rsp_ok_s  = rsp_s & ~drop_q & ~imem_err;
    rsp_bad_s = rsp_s & ~drop_q & imem_err;
    issue_s   = ~rst & ~redirect_valid & (state_q == RUN) & ~outstanding_q & ~drop_q
              & (count_q < CNT_W'(DEPTH));
`ifdef FETCH_BYPASS_EN
    bypass_s  = q_empty_s & rsp_ok_s & ~redirect_valid;
`else
    bypass_s  = 1'b0;
`endif
    head_valid_s = ~q_empty_s | bypass_s;
    qpop_s       = ~q_empty_s & inst_ready & ~redirect_valid;
    push_s       = rsp_ok_s & ~redirect_valid & ~(bypass_s & inst_ready);
  end

  // Decode-side and I-mem-side outputs.
  always_comb begin
    imem_req     = issue_s;
    imem_addr    = pc_q;
    inst_valid   = head_valid_s;
    err          = err_q;
    inst_data    = {INSTR_W{1'b0}};
    inst_pc      = {ADDR_W{1'b0}};
    inst_pc_next = {ADDR_W{1'b0}};
    if (bypass_s) begin
      inst_data    = imem_rdata;
      inst_pc      = req_pc_q;
      inst_pc_next = req_pc_q + ADDR_W'(PC_INC);
    end else if (!q_empty_s) begin
      inst_data    = mem_data_q[rd_ptr_q];
      inst_pc      = mem_pc_q[rd_ptr_q];
      inst_pc_next = mem_pc_q[rd_ptr_q] + ADDR_W'(PC_INC);
    end else begin
      inst_data    = {INSTR_W{1'b0}};
      inst_pc      = {ADDR_W{1'b0}};
      inst_pc_next = {ADDR_W{1'b0}};
    end
  end

  // Next-state: FSM, PC, request tracking and queue bookkeeping; redirect wins over everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    err_d         = err_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_data_d    = mem_data_q;
    mem_pc_d      = mem_pc_q;
    if (redirect_valid) begin
      state_d       = RUN;
      pc_d          = redirect_pc;
      count_d       = CNT_W'(0);
      rd_ptr_d      = PTR_W'(0);
      wr_ptr_d      = PTR_W'(0);
      // A request still in flight must have its response discarded.
      outstanding_d = outstanding_q & ~imem_rvalid;
      drop_d        = outstanding_q & ~imem_rvalid;
    end else begin
      if (issue_s) begin
        pc_d          = pc_q + ADDR_W'(PC_INC);
        req_pc_d      = pc_q;
        outstanding_d = 1'b1;
      end else if (rsp_s) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end else begin
        outstanding_d = outstanding_q;
      end
      if (rsp_bad_s) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        err_d   = err_q;
      end
      if (push_s) begin
        mem_data_d[wr_ptr_q] = imem_rdata;
        mem_pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d             = wr_ptr_q;
      end
      if (qpop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, qpop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      req_pc_q      <= {ADDR_W{1'b0}};
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= CNT_W'(0);
      rd_ptr_q      <= PTR_W'(0);
      wr_ptr_q      <= PTR_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= {INSTR_W{1'b0}};
        mem_pc_q[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      err_q         <= err_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_data_q    <= mem_data_d;
      mem_pc_q      <= mem_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed self-checking bench for fetch_prefetch_queue; I-mem model answers with rdata = addr ^ 0xA5A5.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        imem_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_next;
  logic        err;

  int          n_cmp;
  int          n_mis;
  int          lat;
  logic        err_en;
  logic [15:0] err_addr;

  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc_next(inst_pc_next),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // I-mem model: one request at a time, answered lat cycles after the request cycle.
  initial begin : imem_model
    logic [15:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    imem_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && rst === 1'b0) begin
        a = imem_addr;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = a ^ 16'hA5A5;
        imem_err    = err_en && (a == err_addr);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    inst_ready = 1'b0; err_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    logic [15:0] a2;
    lat = 1; inst_ready = 1'b1;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (inst_data !== 16'h0000) begin n_mis++; $display("FAIL reset_data: got %h expected 0000", inst_data); end
    n_cmp++; if (inst_pc !== 16'h0000) begin n_mis++; $display("FAIL reset_pc: got %h expected 0000", inst_pc); end
    n_cmp++; if (inst_pc_next !== 16'h0000) begin n_mis++; $display("FAIL reset_pc_next: got %h expected 0000", inst_pc_next); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_mis++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_mis++; $display("FAIL post_reset_req: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_mis++; $display("FAIL post_reset_addr: got %h expected 0000", imem_addr); end
    seen = 1'b0; a2 = 16'hxxxx;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin seen = 1'b1; a2 = imem_addr; end
    end
    n_cmp++; if (!seen || a2 !== 16'h0002) begin n_mis++; $display("FAIL post_reset_next_addr: got %h expected 0002", a2); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc;
    int got, last_cyc;
    do_reset();
    lat = 1; inst_ready = 1'b1;
    exp_pc = 16'h0000; got = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        n_cmp++; if (inst_pc !== exp_pc) begin n_mis++; $display("FAIL stream_pc: got %h expected %h", inst_pc, exp_pc); end
        n_cmp++; if (inst_data !== (exp_pc ^ 16'hA5A5)) begin n_mis++; $display("FAIL stream_data: got %h expected %h", inst_data, exp_pc ^ 16'hA5A5); end
        n_cmp++; if (inst_pc_next !== exp_pc + 16'd2) begin n_mis++; $display("FAIL stream_pc_next: got %h expected %h", inst_pc_next, exp_pc + 16'd2); end
        if (got > 0) begin
          n_cmp++; if (cyc - last_cyc !== 2) begin n_mis++; $display("FAIL stream_gap: got %0d expected 2", cyc - last_cyc); end
        end
        got++; exp_pc = exp_pc + 16'd2; last_cyc = cyc;
      end
    end
    n_cmp++; if (got !== 8) begin n_mis++; $display("FAIL stream_count: got %0d expected 8", got); end
  endtask

  task automatic test_backpressure();
    int nreq, got;
    bit seen;
    logic [15:0] exp_pc, a;
    do_reset();
    lat = 1; inst_ready = 1'b0; nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req === 1'b1) nreq++;
    end
    n_cmp++; if (nreq !== 4) begin n_mis++; $display("FAIL bp_fetched: got %0d expected 4", nreq); end
    n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL bp_req_full: got %b expected 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid: got %b expected 1", inst_valid); end
    @(posedge clk);
    #1 inst_ready = 1'b1;
    got = 0; seen = 1'b0; exp_pc = 16'h0000; a = 16'hxxxx;
    for (int cyc = 0; cyc < 30 && (got < 4 || !seen); cyc++) begin
      @(negedge clk);
      if (inst_valid === 1'b1 && got < 4) begin
        n_cmp++; if (inst_pc !== exp_pc) begin n_mis++; $display("FAIL bp_order: got %h expected %h", inst_pc, exp_pc); end
        exp_pc = exp_pc + 16'd2; got++;
      end
      if (imem_req === 1'b1 && !seen) begin seen = 1'b1; a = imem_addr; end
    end
    n_cmp++; if (got !== 4) begin n_mis++; $display("FAIL bp_drained: got %0d expected 4", got); end
    n_cmp++; if (!seen || a !== 16'h0008) begin n_mis++; $display("FAIL bp_resume_addr: got %h expected 0008", a); end
  endtask

  task automatic test_redirect_inflight();
    bit seen, got_inst;
    int first_req;
    logic [15:0] a, p, d;
    do_reset();
    lat = 3; inst_ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) seen = 1'b1;
    end
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL redir_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL redir_req: got %b expected 0", imem_req); end
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    first_req = -1; got_inst = 1'b0; a = 16'hxxxx; p = 16'hxxxx; d = 16'hxxxx;
    for (int idx = 0; idx < 30; idx++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && first_req < 0) begin first_req = idx; a = imem_addr; end
      if (inst_valid === 1'b1 && !got_inst) begin got_inst = 1'b1; p = inst_pc; d = inst_data; end
    end
    n_cmp++; if (first_req !== 2) begin n_mis++; $display("FAIL redir_issue_cycle: got %0d expected 2", first_req); end
    n_cmp++; if (a !== 16'h0100) begin n_mis++; $display("FAIL redir_addr: got %h expected 0100", a); end
    n_cmp++; if (!got_inst || p !== 16'h0100) begin n_mis++; $display("FAIL redir_first_pc: got %h expected 0100", p); end
    n_cmp++; if (d !== (16'h0100 ^ 16'hA5A5)) begin n_mis++; $display("FAIL redir_first_data: got %h expected %h", d, 16'h0100 ^ 16'hA5A5); end
  endtask

  task automatic test_wrap();
    int got;
    logic [15:0] pc0, pc1, nx0, d0;
    do_reset();
    lat = 1; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    got = 0; pc0 = 16'hxxxx; pc1 = 16'hxxxx; nx0 = 16'hxxxx; d0 = 16'hxxxx;
    for (int i = 0; i < 20 && got < 2; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        if (got == 0) begin pc0 = inst_pc; nx0 = inst_pc_next; d0 = inst_data; end
        else begin pc1 = inst_pc; end
        got++;
      end
    end
    n_cmp++; if (pc0 !== 16'hFFFE) begin n_mis++; $display("FAIL wrap_pc0: got %h expected fffe", pc0); end
    n_cmp++; if (nx0 !== 16'h0000) begin n_mis++; $display("FAIL wrap_pc_next0: got %h expected 0000", nx0); end
    n_cmp++; if (d0 !== (16'hFFFE ^ 16'hA5A5)) begin n_mis++; $display("FAIL wrap_data0: got %h expected %h", d0, 16'hFFFE ^ 16'hA5A5); end
    n_cmp++; if (pc1 !== 16'h0000) begin n_mis++; $display("FAIL wrap_pc1: got %h expected 0000", pc1); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL wrap_err: got %b expected 0", err); end
  endtask

  task automatic test_error();
    int nreq, got;
    logic [15:0] exp_pc;
    do_reset();
    lat = 1; inst_ready = 1'b1; err_en = 1'b1; err_addr = 16'h0006;
    nreq = 0; got = 0; exp_pc = 16'h0000;
    repeat (30) begin
      @(negedge clk);
      if (imem_req === 1'b1) nreq++;
      if (inst_valid === 1'b1) begin
        n_cmp++; if (inst_pc !== exp_pc) begin n_mis++; $display("FAIL err_entry_pc: got %h expected %h", inst_pc, exp_pc); end
        exp_pc = exp_pc + 16'd2; got++;
      end
    end
    n_cmp++; if (nreq !== 4) begin n_mis++; $display("FAIL err_req_count: got %0d expected 4", nreq); end
    n_cmp++; if (got !== 3) begin n_mis++; $display("FAIL err_delivered: got %0d expected 3", got); end
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL err_flag: got %b expected 1", err); end
    n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL err_halt_req: got %b expected 0", imem_req); end
    err_en = 1'b0;
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 16'h0010;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1) begin n_mis++; $display("FAIL err_restart_req: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0010) begin n_mis++; $display("FAIL err_restart_addr: got %h expected 0010", imem_addr); end
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_bypass();
    bit seen;
    logic v0, v1;
    logic [15:0] p0, p1;
    do_reset();
    lat = 1; inst_ready = 1'b1;
    seen = 1'b0; v0 = 1'bx; p0 = 16'hxxxx;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_rvalid === 1'b1) begin seen = 1'b1; v0 = inst_valid; p0 = inst_pc; end
    end
    @(negedge clk);
    v1 = inst_valid; p1 = inst_pc;
    n_cmp++; if (!seen) begin n_mis++; $display("FAIL byp_response: got none expected one"); end
`ifdef FETCH_BYPASS_EN
    n_cmp++; if (v0 !== 1'b1) begin n_mis++; $display("FAIL byp_valid_rsp_cycle: got %b expected 1", v0); end
    n_cmp++; if (p0 !== 16'h0000) begin n_mis++; $display("FAIL byp_pc_rsp_cycle: got %h expected 0000", p0); end
    n_cmp++; if (v1 !== 1'b0) begin n_mis++; $display("FAIL byp_valid_next: got %b expected 0", v1); end
`else
    n_cmp++; if (v0 !== 1'b0) begin n_mis++; $display("FAIL byp_valid_rsp_cycle: got %b expected 0", v0); end
    n_cmp++; if (v1 !== 1'b1) begin n_mis++; $display("FAIL byp_valid_next: got %b expected 1", v1); end
    n_cmp++; if (p1 !== 16'h0000) begin n_mis++; $display("FAIL byp_pc_next_cycle: got %h expected 0000", p1); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; inst_ready = 1'b0;
    lat = 1; err_en = 1'b0; err_addr = 16'h0000;
    do_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_wrap();
    test_error();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
